// File: rtl/alu_serdes.sv
// Parallel-to-bit-serial front end for a bit-serial ALU: accepts operand bundles,
// streams A/B LSB-first, gathers Y back. Optional flags under ALU_SERDES_FLAGS_EN.
module alu_serdes #(
   parameter int WIDTH = 8,
   parameter int OPW   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [OPW-1:0]   in_op,
   output logic             alu_run,
   output logic [OPW-1:0]   alu_op,
   output logic             alu_a,
   output logic             alu_b,
   input  logic             alu_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             out_zero,
   output logic             out_neg
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_y_sh;
   logic [WIDTH-1:0] r_out_y;
   logic [CW-1:0]    r_count;
   logic [OPW-1:0]   r_op;
   logic             w_accept;
   logic             w_last;
   logic [WIDTH-1:0] w_y_full;

   assign w_accept = (r_state == S_IDLE) && in_valid;
   assign w_last   = (r_state == S_SHIFT) && (r_count == CW'(WIDTH - 1));
   // Result word including the bit the ALU produces in the final serial cycle.
   assign w_y_full = {alu_y, r_y_sh[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (in_valid) w_next = S_SHIFT;
            else          w_next = S_IDLE;
         end
         S_SHIFT: begin
            if (w_last) w_next = S_DONE;
            else        w_next = S_SHIFT;
         end
         S_DONE: begin
            if (out_ready) w_next = S_IDLE;
            else           w_next = S_DONE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      alu_run   = 1'b0;
      out_valid = 1'b0;
      alu_a     = 1'b0;
      alu_b     = 1'b0;
      case (r_state)
         S_IDLE:  in_ready = 1'b1;
         S_SHIFT: begin
            alu_run = 1'b1;
            alu_a   = r_a_sh[0];
            alu_b   = r_b_sh[0];
         end
         S_DONE:  out_valid = 1'b1;
         default: in_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_y_sh  <= '0;
         r_out_y <= '0;
         r_count <= '0;
         r_op    <= '0;
      end else if (w_accept) begin
         r_a_sh  <= in_a;
         r_b_sh  <= in_b;
         r_y_sh  <= '0;
         r_count <= '0;
         r_op    <= in_op;
      end else if (r_state == S_SHIFT) begin
         r_a_sh  <= r_a_sh >> 1;
         r_b_sh  <= r_b_sh >> 1;
         r_y_sh  <= w_y_full;
         r_count <= r_count + CW'(1);
         if (w_last) begin
            r_out_y <= w_y_full;
         end
      end
   end

   assign alu_op = r_op;
   assign out_y  = r_out_y;

`ifdef ALU_SERDES_FLAGS_EN
   logic r_any;
   logic r_zero;
   logic r_neg;

   // Zero is tracked as a sticky OR of every result bit as it streams past.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_any  <= 1'b0;
         r_zero <= 1'b0;
         r_neg  <= 1'b0;
      end else if (w_accept) begin
         r_any  <= 1'b0;
      end else if (r_state == S_SHIFT) begin
         r_any <= r_any | alu_y;
         if (w_last) begin
            r_zero <= ~(r_any | alu_y);
            r_neg  <= alu_y;
         end
      end
   end

   assign out_zero = r_zero;
   assign out_neg  = r_neg;
`else
   assign out_zero = 1'b0;
   assign out_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serdes.sv
// Self-checking bench for alu_serdes with a behavioural bit-serial ALU attached;
// results checked against word-level arithmetic.
module tb_alu_serdes;

   localparam int W = 8;
`ifdef ALU_SERDES_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic [2:0]   in_op;
   logic         alu_run;
   logic [2:0]   alu_op;
   logic         alu_a;
   logic         alu_b;
   logic         alu_y;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_y;
   logic         out_zero;
   logic         out_neg;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_serdes #(.WIDTH(W), .OPW(3)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .alu_run(alu_run), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_y(out_y), .out_zero(out_zero), .out_neg(out_neg)
   );

   // Serial ALU: carry/borrow cleared whenever alu_run is low.
   logic c_r;
   logic c_nx;
   always_comb begin
      c_nx  = 1'b0;
      alu_y = 1'b0;
      case (alu_op)
         3'd0: begin alu_y = alu_a ^ alu_b ^ c_r; c_nx = (alu_a & alu_b) | (c_r & (alu_a ^ alu_b)); end
         3'd1: begin alu_y = alu_a ^ alu_b ^ c_r; c_nx = (~alu_a & alu_b) | (~(alu_a ^ alu_b) & c_r); end
         3'd2: alu_y = alu_a | alu_b;
         3'd3: alu_y = alu_a & alu_b;
         3'd4: alu_y = alu_a ^ alu_b;
         3'd5: alu_y = ~alu_a;
         3'd6: alu_y = alu_a;
         default: alu_y = alu_b;
      endcase
   end
   always @(posedge clk) begin
      if (!alu_run) c_r <= 1'b0;
      else          c_r <= c_nx;
   end

   function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      case (op)
         3'd0: ref_alu = a + b;
         3'd1: ref_alu = a - b;
         3'd2: ref_alu = a | b;
         3'd3: ref_alu = a & b;
         3'd4: ref_alu = a ^ b;
         3'd5: ref_alu = ~a;
         3'd6: ref_alu = a;
         default: ref_alu = b;
      endcase
   endfunction

   function automatic logic exp_zero(input logic [W-1:0] y);
      exp_zero = FLAGS ? (y == '0) : 1'b0;
   endfunction

   function automatic logic exp_neg(input logic [W-1:0] y);
      exp_neg = FLAGS ? y[W-1] : 1'b0;
   endfunction

   // Presents a bundle and returns #1 after the edge that accepted it.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op, output bit ok);
      ok = 1'b0;
      @(negedge clk);
      in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (in_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (ok) begin @(posedge clk); #1; end
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int edges, output int runs, output bit ok);
      edges = 0; ok = 1'b0;
      runs = alu_run ? 1 : 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         edges++;
         if (out_valid) begin ok = 1'b1; break; end
         if (alu_run) runs++;
      end
   endtask

   task automatic pop;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      n_vec++;
      if ({in_ready, out_valid, alu_run, alu_a, alu_b} !== 5'b10000) begin
         n_err++; $display("FAIL reset_ctl: got %b expected 10000", {in_ready, out_valid, alu_run, alu_a, alu_b});
      end
      n_vec++;
      if ({alu_op, out_y, out_zero, out_neg} !== 13'd0) begin
         n_err++; $display("FAIL reset_data: got op=%h y=%h z=%b n=%b expected all 0", alu_op, out_y, out_zero, out_neg);
      end
   endtask

   task automatic test_add_latency;
      bit ok; int edges; int runs;
      issue(8'h5A, 8'h3C, 3'd0, ok);
      n_vec++;
      if (!ok || alu_op !== 3'd0 || in_ready !== 1'b0) begin
         n_err++; $display("FAIL add_accept: got ok=%b op=%h rdy=%b expected 1 0 0", ok, alu_op, in_ready);
      end
      wait_valid(edges, runs, ok);
      n_vec++;
      if (!ok || edges != W || runs != W) begin
         n_err++; $display("FAIL add_timing: got ok=%b edges=%0d runs=%0d expected 1 %0d %0d", ok, edges, runs, W, W);
      end
      n_vec++;
      if (out_y !== 8'h96 || out_zero !== exp_zero(8'h96) || out_neg !== exp_neg(8'h96) || alu_run !== 1'b0) begin
         n_err++; $display("FAIL add_result: got y=%h z=%b n=%b run=%b expected 96", out_y, out_zero, out_neg, alu_run);
      end
      pop();
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++; $display("FAIL add_pop: got valid=%b rdy=%b expected 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_sub_xor;
      bit ok; int edges; int runs;
      issue(8'h10, 8'h20, 3'd1, ok);
      wait_valid(edges, runs, ok);
      n_vec++;
      if (!ok || out_y !== 8'hF0 || out_neg !== exp_neg(8'hF0) || out_zero !== exp_zero(8'hF0)) begin
         n_err++; $display("FAIL sub: got y=%h z=%b n=%b expected F0 z=%b n=%b", out_y, out_zero, out_neg, exp_zero(8'hF0), exp_neg(8'hF0));
      end
      pop();
      issue(8'hA5, 8'hA5, 3'd4, ok);
      wait_valid(edges, runs, ok);
      n_vec++;
      if (!ok || out_y !== 8'h00 || out_zero !== exp_zero(8'h00) || out_neg !== 1'b0) begin
         n_err++; $display("FAIL xor: got y=%h z=%b n=%b expected 00 z=%b n=0", out_y, out_zero, out_neg, exp_zero(8'h00));
      end
      pop();
   endtask

   task automatic test_backpressure;
      bit ok; int edges; int runs;
      issue(8'hFF, 8'h01, 3'd0, ok);
      wait_valid(edges, runs, ok);
      in_a = 8'h77; in_b = 8'h11; in_op = 3'd3; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         n_vec++;
         if (!ok || out_valid !== 1'b1 || in_ready !== 1'b0 || out_y !== 8'h00 || out_zero !== exp_zero(8'h00)) begin
            n_err++; $display("FAIL hold%0d: got v=%b rdy=%b y=%h z=%b expected 1 0 00 %b", i, out_valid, in_ready, out_y, out_zero, exp_zero(8'h00));
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      pop();
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_run !== 1'b0) begin
         n_err++; $display("FAIL hold_release: got v=%b rdy=%b run=%b expected 0 1 0", out_valid, in_ready, alu_run);
      end
   endtask

   task automatic test_back_to_back;
      bit ok; int nres; int gap; int e1; int e2;
      logic [W-1:0] y1;
      logic [W-1:0] y2;
      nres = 0; gap = 0; e1 = 0; e2 = 0; y1 = '0; y2 = '0;
      out_ready = 1'b1;
      issue(8'hF0, 8'h0F, 3'd2, ok);
      in_a = 8'h3C; in_b = 8'($urandom); in_op = 3'd5; in_valid = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            nres++;
            if (nres == 1) begin y1 = out_y; e1 = e; end
            else           begin y2 = out_y; e2 = e; end
         end
         if (nres == 1 && !alu_run) gap++;
         if (nres >= 1 && !in_ready && !out_valid) in_valid = 1'b0;
         if (nres == 2) break;
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid = 1'b0;
      n_vec++;
      if (!ok || nres != 2 || y1 !== 8'hFF || y2 !== 8'hC3) begin
         n_err++; $display("FAIL b2b_data: got n=%0d y1=%h y2=%h expected 2 FF C3", nres, y1, y2);
      end
      n_vec++;
      if (e2 - e1 != W + 2 || gap < 1) begin
         n_err++; $display("FAIL b2b_rate: got period=%0d gap=%0d expected %0d >=1", e2 - e1, gap, W + 2);
      end
   endtask

   task automatic test_reset_midop;
      bit ok; int edges; int runs; int glitch;
      issue(8'hFF, 8'hFF, 3'd0, ok);
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || alu_run !== 1'b0 || out_y !== 8'h00 || alu_op !== 3'd0) begin
         n_err++; $display("FAIL midrst: got rdy=%b v=%b run=%b y=%h op=%h expected 1 0 0 00 0", in_ready, out_valid, alu_run, out_y, alu_op);
      end
      glitch = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid) glitch++;
      end
      n_vec++;
      if (glitch != 0) begin
         n_err++; $display("FAIL midrst_glitch: got %0d valid cycles expected 0", glitch);
      end
      issue(8'h01, 8'h01, 3'd0, ok);
      wait_valid(edges, runs, ok);
      n_vec++;
      if (!ok || out_y !== 8'h02) begin
         n_err++; $display("FAIL midrst_next: got y=%h expected 02", out_y);
      end
      pop();
   endtask

   task automatic test_random;
      bit ok; int edges; int runs;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [2:0] op;
      logic [W-1:0] y;
      for (int n = 0; n < 24; n++) begin
         a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 7));
         y = ref_alu(op, a, b);
         issue(a, b, op, ok);
         wait_valid(edges, runs, ok);
         n_vec++;
         if (!ok || edges != W || out_y !== y || out_zero !== exp_zero(y) || out_neg !== exp_neg(y)) begin
            n_err++; $display("FAIL rand%0d: op=%0d a=%h b=%h got y=%h z=%b n=%b edges=%0d expected %h %b %b %0d",
                              n, op, a, b, out_y, out_zero, out_neg, edges, y, exp_zero(y), exp_neg(y), W);
         end
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         pop();
      end
   endtask

   initial begin
      test_reset();
      test_add_latency();
      test_sub_xor();
      test_backpressure();
      test_back_to_back();
      test_reset_midop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
